// File: rtl/spi_sched_pkg.sv
// ---------------------------------------------------------------------------
// spi_sched_pkg
// Shared types and constants for the SPI bus scheduler.
//   state_e : scheduler FSM state encoding (3 bits)
//   N       : number of requesters sharing the SPI master
//   BYTE_W  : width of one SPI transfer
//   SEL_W   : width of the per-requester clock-divider select
// ---------------------------------------------------------------------------
package spi_sched_pkg;

    localparam int N      = 4;
    localparam int BYTE_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMPLETE  = 3'd4,
        ST_RELEASE   = 3'd5
    } state_e;

endpackage

// File: rtl/spi_bus_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational 4-way round-robin picker. The search starts at 'ptr' and
// walks upward with 2-bit wrap-around; the first active request wins.
//   req        in  4  request levels
//   ptr        in  2  index with highest priority this round
//   gnt_onehot out 4  one-hot winner (all zero when req is zero)
//   idx        out 2  binary index of the winner (ptr when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter
    import spi_sched_pkg::*;
(
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [1:0]   idx
);

    logic [1:0] cand;
    logic       found;

    // Walk the requesters in priority order starting at ptr; the 2-bit
    // candidate index wraps from 3 back to 0 on its own.
    always_comb begin
        gnt_onehot = '0;
        idx        = ptr;
        cand       = ptr;
        found      = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found            = 1'b1;
                idx              = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_scheduler.sv
// ---------------------------------------------------------------------------
// spi_bus_scheduler
// Shares one SPI master among four requesters. Arbitrates round-robin,
// holds the grant across multi-byte bursts, launches each byte on the
// master with the owner's address / polarity / divider select, and returns
// the received byte. A start that the master never acknowledges with busy
// is abandoned after TIMEOUT cycles and reported on err.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req[4]            per-requester request level
//   tx_data[32]       per-requester TX byte, requester i uses [8i+7:8i]
//   last[4]           per-requester "this byte ends the burst"
//   gnt[4]            one-hot grant
//   ack[4]            pulse: owner's tx_data/last were sampled
//   rx_valid, rx_data pulse + received byte for the owner
//   err               pulse: master never raised busy
//   m_start, m_tx, m_addr, m_cpol, m_clk_sel   master control outputs
//   m_busy, m_rx      master status / received byte
// ---------------------------------------------------------------------------
module spi_bus_scheduler #(
    parameter int              N           = 4,
    parameter logic [3*N-1:0]  CLK_SEL_VEC = 12'h000,
    parameter logic [N-1:0]    CPOL_VEC    = 4'b0000,
    parameter int              TIMEOUT     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] tx_data,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic           rx_valid,
    output logic [7:0]     rx_data,
    output logic           err,
    output logic           m_start,
    output logic [7:0]     m_tx,
    output logic [3:0]     m_addr,
    output logic           m_cpol,
    output logic [2:0]     m_clk_sel,
    input  logic           m_busy,
    input  logic [7:0]     m_rx
);

    import spi_sched_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      ack_q, ack_d;
    logic              rx_valid_q, rx_valid_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              err_q, err_d;
    logic              m_start_q, m_start_d;
    logic [BYTE_W-1:0] m_tx_q, m_tx_d;
    logic [3:0]        m_addr_q, m_addr_d;
    logic              m_cpol_q, m_cpol_d;
    logic [SEL_W-1:0]  m_clk_sel_q, m_clk_sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N-1:0]      arb_gnt;
    logic [1:0]        arb_idx;

    rr_arbiter u_arb (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_onehot (arb_gnt),
        .idx        (arb_idx)
    );

    // Next-state and datapath logic. Pulses (ack, m_start, rx_valid, err)
    // default low so each lasts exactly one cycle. The master control
    // outputs only change in LAUNCH, so they stay stable for the whole byte.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        err_d       = 1'b0;
        m_start_d   = 1'b0;
        m_tx_d      = m_tx_q;
        m_addr_d    = m_addr_q;
        m_cpol_d    = m_cpol_q;
        m_clk_sel_d = m_clk_sel_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    state_d = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                m_start_d   = 1'b1;
                ack_d       = gnt_q;
                m_tx_d      = tx_data[BYTE_W*int'(owner_q) +: BYTE_W];
                m_addr_d    = {2'b00, owner_q};
                m_cpol_d    = CPOL_VEC[owner_q];
                m_clk_sel_d = CLK_SEL_VEC[SEL_W*int'(owner_q) +: SEL_W];
                last_d      = last[owner_q];
                cnt_d       = '0;
                state_d     = ST_WAIT_BUSY;
            end

            // Counter value k means k+1 cycles have been spent here, so
            // err fires after exactly TIMEOUT cycles without busy.
            ST_WAIT_BUSY: begin
                if (m_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!m_busy) begin
                    rx_data_d  = m_rx;
                    rx_valid_d = 1'b1;
                    state_d    = ST_COMPLETE;
                end
            end

            // Only the owner's request is looked at mid-burst.
            ST_COMPLETE: begin
                if (last_q || !req[owner_q]) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end

            ST_RELEASE: begin
                gnt_d   = '0;
                ptr_d   = owner_q + 2'd1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ack_q       <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            err_q       <= 1'b0;
            m_start_q   <= 1'b0;
            m_tx_q      <= '0;
            m_addr_q    <= '0;
            m_cpol_q    <= 1'b0;
            m_clk_sel_q <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            err_q       <= err_d;
            m_start_q   <= m_start_d;
            m_tx_q      <= m_tx_d;
            m_addr_q    <= m_addr_d;
            m_cpol_q    <= m_cpol_d;
            m_clk_sel_q <= m_clk_sel_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign err       = err_q;
    assign m_start   = m_start_q;
    assign m_tx      = m_tx_q;
    assign m_addr    = m_addr_q;
    assign m_cpol    = m_cpol_q;
    assign m_clk_sel = m_clk_sel_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spi_bus_scheduler
// Drives spi_bus_scheduler through directed and randomized bursts. A small
// behavioural SPI master answers each start with busy and returns either a
// fixed byte or the inverted TX byte. Expected grants follow round-robin
// order computed from a plain pointer kept by the bench.
// ---------------------------------------------------------------------------
module tb_spi_bus_scheduler;

    localparam int          TMO        = 16;
    localparam logic [11:0] TB_CLK_SEL = 12'b101_011_110_001;
    localparam logic [3:0]  TB_CPOL    = 4'b1010;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] tx_data;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        err;
    logic        m_start;
    logic [7:0]  m_tx;
    logic [3:0]  m_addr;
    logic        m_cpol;
    logic [2:0]  m_clk_sel;
    logic        m_busy;
    logic [7:0]  m_rx;

    int          checks = 0;
    int          errors = 0;
    int          exp_ptr;

    bit          master_on;
    bit          fixed_en;
    logic [7:0]  fixed_rx;
    int          busy_len_min;
    int          busy_len_max;
    logic [7:0]  master_rsp;

    spi_bus_scheduler #(
        .N           (4),
        .CLK_SEL_VEC (TB_CLK_SEL),
        .CPOL_VEC    (TB_CPOL),
        .TIMEOUT     (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tx_data   (tx_data),
        .last      (last),
        .gnt       (gnt),
        .ack       (ack),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .err       (err),
        .m_start   (m_start),
        .m_tx      (m_tx),
        .m_addr    (m_addr),
        .m_cpol    (m_cpol),
        .m_clk_sel (m_clk_sel),
        .m_busy    (m_busy),
        .m_rx      (m_rx)
    );

    always #5 clk = ~clk;

    // Behavioural SPI master: after a start it waits 0..3 cycles, holds
    // busy for a random length, then drops busy with the reply byte.
    always begin : master_model
        @(posedge clk);
        #1;
        if (master_on && m_start === 1'b1) begin
            master_rsp = fixed_en ? fixed_rx : ~m_tx;
            repeat ($urandom_range(3, 0)) begin
                @(posedge clk);
                #1;
            end
            m_busy = 1'b1;
            repeat ($urandom_range(busy_len_max, busy_len_min)) begin
                @(posedge clk);
                #1;
            end
            m_rx   = master_rsp;
            m_busy = 1'b0;
        end
    end

    // Keeps the run bounded even if the DUT wedges in an unexpected way.
    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int who, input logic [7:0] b, input logic l);
        tx_data[8*who +: 8] = b;
        last[who]           = l;
    endtask

    // Round-robin reference: first active request at or after p.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    task automatic checkResetOutputs();
        checkOutput("rst_gnt",       32'(gnt),       32'h0);
        checkOutput("rst_ack",       32'(ack),       32'h0);
        checkOutput("rst_rx_valid",  32'(rx_valid),  32'h0);
        checkOutput("rst_rx_data",   32'(rx_data),   32'h0);
        checkOutput("rst_err",       32'(err),       32'h0);
        checkOutput("rst_m_start",   32'(m_start),   32'h0);
        checkOutput("rst_m_tx",      32'(m_tx),      32'h0);
        checkOutput("rst_m_addr",    32'(m_addr),    32'h0);
        checkOutput("rst_m_cpol",    32'(m_cpol),    32'h0);
        checkOutput("rst_m_clk_sel", 32'(m_clk_sel), 32'h0);
    endtask

    // Runs one burst starting from an IDLE sample point with req already
    // driven. drop_byte >= 0 deasserts the owner's req during that byte.
    task automatic doBurst(input int nbytes, input int drop_byte);
        int         owner;
        logic [3:0] oh;
        logic [7:0] txb;
        logic [7:0] exp_rx;
        bit         ok;
        int         extra;
        owner = pick(req, exp_ptr);
        oh    = 4'b0001 << owner;
        txb   = 8'($urandom);
        applyStimulus(owner, txb, nbytes == 1);
        for (int b = 0; b < nbytes; b++) begin
            cyc();
            checkOutput("gnt_launch", 32'(gnt), 32'(oh));
            cyc();
            checkOutput("m_start",   32'(m_start),   32'h1);
            checkOutput("ack",       32'(ack),       32'(oh));
            checkOutput("m_tx",      32'(m_tx),      32'(txb));
            checkOutput("m_addr",    32'(m_addr),    32'(owner));
            checkOutput("m_cpol",    32'(m_cpol),    32'(TB_CPOL[owner]));
            checkOutput("m_clk_sel", 32'(m_clk_sel), 32'(TB_CLK_SEL[3*owner +: 3]));
            exp_rx = fixed_en ? fixed_rx : ~txb;
            if (b < nbytes - 1) begin
                txb = 8'($urandom);
                applyStimulus(owner, txb, (b + 1) == (nbytes - 1));
            end
            if (b == drop_byte) req[owner] = 1'b0;
            ok    = 1'b0;
            extra = 0;
            for (int i = 0; i < 64; i++) begin
                cyc();
                if (m_start === 1'b1) extra++;
                if (rx_valid === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            checkOutput("rx_valid_seen", 32'(ok),      32'h1);
            checkOutput("rx_data",       32'(rx_data), 32'(exp_rx));
            checkOutput("single_start",  32'(extra),   32'h0);
            checkOutput("gnt_hold",      32'(gnt),     32'(oh));
            if (b == drop_byte) break;
        end
        cyc();
        checkOutput("gnt_in_release", 32'(gnt),      32'(oh));
        checkOutput("rx_valid_pulse", 32'(rx_valid), 32'h0);
        cyc();
        checkOutput("gnt_idle",     32'(gnt),     32'h0);
        checkOutput("idle_m_start", 32'(m_start), 32'h0);
        exp_ptr = (owner + 1) % 4;
    endtask

    initial begin : stimulus
        int         cnt;
        int         rxv;
        bit         ok;
        logic [3:0] r;

        rst          = 1'b1;
        req          = '0;
        tx_data      = '0;
        last         = '0;
        m_busy       = 1'b0;
        m_rx         = '0;
        master_on    = 1'b1;
        fixed_en     = 1'b0;
        fixed_rx     = '0;
        busy_len_min = 1;
        busy_len_max = 4;
        exp_ptr      = 0;

        $display("[TB] reset");
        repeat (3) cyc();
        checkResetOutputs();
        rst = 1'b0;
        cyc();

        $display("[TB] contention: order 0,1,2,3,0");
        req = 4'b1111;
        for (int k = 0; k < 5; k++) doBurst(1, -1);

        $display("[TB] single byte A5 -> 3C");
        req      = 4'b0001;
        fixed_en = 1'b1;
        fixed_rx = 8'h3C;
        doBurst(1, -1);
        fixed_en = 1'b0;

        $display("[TB] burst of 4 on requester 2, requester 0 waiting");
        req = 4'b0101;
        doBurst(4, -1);
        req[2] = 1'b0;
        doBurst(1, -1);

        $display("[TB] early drop by requester 1");
        req = 4'b0010;
        doBurst(5, 1);
        req = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (m_start === 1'b1) cnt++;
        end
        checkOutput("no_third_start", 32'(cnt), 32'h0);

        $display("[TB] timeout");
        master_on = 1'b0;
        req       = 4'b0100;
        applyStimulus(2, 8'($urandom), 1'b1);
        cyc();
        checkOutput("tmo_gnt", 32'(gnt), 32'h4);
        cyc();
        checkOutput("tmo_m_start", 32'(m_start), 32'h1);
        cnt = 0;
        rxv = 0;
        for (int i = 1; i < TMO; i++) begin
            cyc();
            if (err === 1'b1) cnt++;
            if (rx_valid === 1'b1) rxv++;
        end
        checkOutput("tmo_err_early", 32'(cnt), 32'h0);
        cyc();
        checkOutput("tmo_err", 32'(err), 32'h1);
        if (rx_valid === 1'b1) rxv++;
        checkOutput("tmo_no_rx_valid", 32'(rxv), 32'h0);
        req = 4'b0000;
        cyc();
        checkOutput("tmo_err_pulse", 32'(err), 32'h0);
        checkOutput("tmo_gnt_clear", 32'(gnt), 32'h0);
        exp_ptr   = 3;
        master_on = 1'b1;

        $display("[TB] randomized bursts");
        for (int it = 0; it < 10; it++) begin
            r   = 4'($urandom_range(15, 1));
            req = r;
            doBurst(int'($urandom_range(3, 1)), -1);
        end

        $display("[TB] reset during WAIT_DONE");
        busy_len_min = 12;
        busy_len_max = 12;
        req          = 4'b0100;
        applyStimulus(2, 8'($urandom), 1'b1);
        cyc();
        cyc();
        checkOutput("rst_test_m_start", 32'(m_start), 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        checkOutput("rst_test_busy_seen", 32'(ok), 32'h1);
        cyc();
        rst = 1'b1;
        req = 4'b0000;
        cyc();
        checkResetOutputs();
        rst     = 1'b0;
        exp_ptr = 0;
        ok      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (m_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("rst_test_master_idle", 32'(ok), 32'h1);
        busy_len_min = 1;
        busy_len_max = 4;
        cyc();
        req = 4'b1111;
        doBurst(1, -1);
        req = 4'b1000;
        doBurst(1, -1);
        req = 4'b0000;
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_bus_scheduler.md
# spi_bus_scheduler

Round-robin scheduler that shares one SPI master among four requesters. It arbitrates byte-level requests, holds the grant across multi-byte bursts and launches each byte on the master. It applies each requester's slave address, clock-divider select and clock polarity, and returns the received byte to the owner. The block sits between client logic (sensor/DAC/flash drivers) and the SPI master, and is the only agent that drives the master's control inputs.

## Interface
Parameters:
- `N`, 4: number of requesters; fixed at 4 in this revision.
- `CLK_SEL_VEC`, 12'h000: per-requester 3-bit divider select; requester i uses bits [3i+2:3i].
- `CPOL_VEC`, 4'b0000: per-requester clock polarity; bit i belongs to requester i.
- `TIMEOUT`, 16: cycles allowed for master `busy` to rise after a start.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  per-requester request level.
- `tx_data`  in  32  per-requester TX byte; requester i uses [8i+7:8i].
- `last`  in  4  per-requester flag: the current byte ends the burst.
- `gnt`  out  4  one-hot grant.
- `ack`  out  4  one-cycle pulse: the owner's `tx_data`/`last` were sampled.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` is valid for the owner.
- `rx_data`  out  8  received byte.
- `err`  out  1  one-cycle pulse: the master did not respond (timeout).
- `m_start`  out  1  one-cycle launch pulse to the master.
- `m_tx`  out  8  byte to shift out.
- `m_addr`  out  4  slave index; equals the owner index.
- `m_cpol`  out  1  polarity for the owner.
- `m_clk_sel`  out  3  divider select for the owner.
- `m_busy`  in  1  master busy.
- `m_rx`  in  8  master received byte; valid when `m_busy` falls.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE, RELEASE.
- IDLE: if `req` != 0, pick the winner by round-robin starting at pointer `ptr`, register the one-hot `gnt`, then go to LAUNCH.
- LAUNCH (one cycle):
  - Drive `m_start`=1 and set `ack[owner]`.
  - Latch `m_tx`, `m_addr`, `m_cpol`, `m_clk_sel` and the owner's `last`.
  - Clear the timeout counter, then go to WAIT_BUSY.
- WAIT_BUSY:
  - `m_busy`=1: go to WAIT_DONE.
  - Counter reaches `TIMEOUT`-1: pulse `err` and go to RELEASE; no `rx_valid` is issued.
- WAIT_DONE: when `m_busy`=0, register `m_rx` into `rx_data` and go to COMPLETE. This state has no timeout.
- COMPLETE:
  - `rx_valid`=1 for this cycle.
  - If latched `last`=1 or `req[owner]`=0: go to RELEASE.
  - Otherwise: go to LAUNCH for the next byte; `gnt` is held throughout.
- RELEASE:
  - Clear `gnt`.
  - `ptr` ← (owner+1) mod 4; 2-bit wrap-around, so owner 3 gives `ptr`=0.
  - Go to IDLE.
- Requesters may change `req` while not granted. Only the owner's `req` is sampled mid-burst, and only in COMPLETE.
- `m_tx`, `m_addr`, `m_cpol` and `m_clk_sel` are stable from LAUNCH until the next LAUNCH.

## Timing
- All outputs are registered.
- Reset values:
  - `gnt`=0, `ack`=0, `rx_valid`=0, `rx_data`=0, `err`=0.
  - `m_start`=0, `m_tx`=0, `m_addr`=0, `m_cpol`=0, `m_clk_sel`=0.
  - `ptr`=0, state=IDLE.
- Reset has priority in every state. A reset mid-burst returns all outputs to their reset values on the next edge; the master is left to finish on its own.
- Sequence for a request seen in IDLE at edge T:
  - `gnt` high after T+1.
  - `m_start` and `ack` high for the cycle after T+2.
  - `rx_valid` appears one cycle after the `m_busy` fall is sampled.
- Minimum gap between consecutive bytes of a burst: 2 cycles from `rx_valid` to the next `m_start` (COMPLETE, then LAUNCH).
- Between bursts the bus is idle for at least 2 cycles (RELEASE, then IDLE).
- If `req` rises in the same cycle the scheduler is in RELEASE, it is considered in the following IDLE cycle.

## Structure
- Package `spi_sched_pkg` holds:
  - the state enum (3-bit);
  - `N`=4;
  - byte width 8;
  - a `SEL_W`=3 localparam.
- Sub-module `rr_arbiter`: combinational 4-way round-robin picker (`req`, `ptr`, `gnt_onehot`, `idx`). The FSM, timeout counter and datapath registers live in the top block.

## Test plan
- Single byte: `req`=4'b0001, `tx_data[7:0]`=8'hA5, `last[0]`=1, master model echoes 8'h3C.
  - `gnt`=0001, one `m_start` with `m_tx`=A5, `m_addr`=0.
  - `rx_valid` with `rx_data`=3C, then `gnt`=0.
- Contention: `req`=4'b1111 held with `last`=1111.
  - Grants follow order 0,1,2,3,0, each for exactly one byte.
  - `m_addr` matches the owner each time.
- Burst: requester 2 with `last[2]`=0 for 3 bytes, then 1.
  - `gnt`=0100 is held for 4 `m_start` pulses.
  - Requester 0, requesting throughout, is granted only after RELEASE.
- Early drop: requester 1 deasserts `req` during the 2nd byte of a burst.
  - That byte completes with `rx_valid`.
  - The grant is then released; there is no third `m_start`.
- Timeout: master model never raises `m_busy` after a start.
  - `err` pulses exactly `TIMEOUT` cycles after WAIT_BUSY entry.
  - No `rx_valid` is issued; `ptr` advances to the next requester.
- Reset mid-transfer: assert `rst` during WAIT_DONE.
  - Next edge: all outputs at their reset values, `ptr`=0.
  - A new `req`=4'b1000 is granted normally.
